// File: rtl/tdc_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : tdc_multi_if
// Brief    : Record stream (valid/ready) from the TDC FIFO head to its consumer.
// Revision : 1.0
// ============================================================================
interface tdc_multi_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 7
);
  logic             out_valid;
  logic             out_ready;
  logic [N_CH-1:0]  out_start_mask;
  logic [N_CH-1:0]  out_end_mask;
  logic [CNT_W-1:0] out_interval;
  logic             out_coinc;

  modport master (
    output out_valid, out_start_mask, out_end_mask, out_interval, out_coinc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_start_mask, out_end_mask, out_interval, out_coinc,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/tdc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tdc_multi
// Brief    : Multi-channel TDC: synchronised hit detection, interval/coincidence
//            measurement and a record FIFO with valid/ready output.
// Revision : 1.0
// ============================================================================
module tdc_multi #(
  parameter int N_CH         = 2,
  parameter int CNT_W        = 7,
  parameter int MAX_INTERVAL = 127,
  parameter int SYNC_STAGES  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_W       = 16
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  input  wire logic                          enable,
  input  wire logic [N_CH-1:0]               pulse_in,
  tdc_multi_if.master                        rec,
  output logic      [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic      [DROP_W-1:0]             drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_max   = CNT_W'(MAX_INTERVAL);
  localparam logic [AW:0]      c_depth = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [N_CH-1:0]  start_mask;
    logic [N_CH-1:0]  end_mask;
    logic [CNT_W-1:0] interval;
    logic             coinc;
  } rec_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  // ---------------------------------------------------------------- front end
  logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
  logic [N_CH-1:0]                  r_dly;
  logic [N_CH-1:0]                  r_hit;
  logic [N_CH-1:0]                  w_sync;
  logic [N_CH-1:0]                  w_edge;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = w_sync & ~r_dly;

  // Hit vector is registered so the popcount/FSM path starts from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= '0;
      r_hit  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
      r_dly  <= w_sync;
      r_hit  <= w_edge;
    end
  end

  // ---------------------------------------------------------------- measurement
  state_t           r_state;
  logic [N_CH-1:0]  r_ref;
  logic [CNT_W-1:0] r_dist;
  logic             r_push;
  rec_t             r_rec;
  logic             w_event;
  logic             w_multi;

  assign w_event = |r_hit;
  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign w_multi = |(r_hit & (r_hit - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ref   <= '0;
      r_dist  <= '0;
      r_push  <= 1'b0;
      r_rec   <= '0;
    end else begin
      r_push <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
      end else if (w_event) begin
        r_ref   <= r_hit;
        r_dist  <= CNT_W'(1);
        r_state <= S_ARMED;
        if (w_multi) begin
          r_push <= 1'b1;
          r_rec  <= '{start_mask: r_hit, end_mask: r_hit, interval: '0, coinc: 1'b1};
        end else if (r_state == S_ARMED) begin
          r_push <= 1'b1;
          r_rec  <= '{start_mask: r_ref, end_mask: r_hit, interval: r_dist, coinc: 1'b0};
        end
      end else if (r_state == S_ARMED) begin
        // A counter at the limit with no event means the next edge would be out of range.
        if (r_dist == c_max) begin
          r_state <= S_IDLE;
        end else begin
          r_dist <= r_dist + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- record FIFO
  rec_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic [DROP_W-1:0] r_drop;
  logic          w_nonempty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  rec_t          w_head;

  assign w_nonempty = (r_level != '0);
  assign w_full     = (r_level == c_depth);
  assign w_pop      = w_nonempty && rec.out_ready;
  assign w_wr       = r_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_drop  <= '0;
    end else begin
      if (w_wr) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (r_push && !w_wr && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr] <= r_rec;
    end
  end

  always_comb begin
    w_head = '0;
    if (w_nonempty) begin
      w_head = r_mem[r_rd];
    end
  end

  assign rec.out_valid      = w_nonempty;
  assign rec.out_start_mask = w_head.start_mask;
  assign rec.out_end_mask   = w_head.end_mask;
  assign rec.out_interval   = w_head.interval;
  assign rec.out_coinc      = w_head.coinc;
  assign fifo_level         = r_level;
  assign drop_count         = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_tdc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_multi
// Brief    : Directed and randomised bench for tdc_multi with an event-time model.
// Revision : 1.0
// ============================================================================
module tb_tdc_multi;

  localparam int N_CH         = 2;
  localparam int CNT_W        = 7;
  localparam int MAX_INTERVAL = 127;
  localparam int SYNC_STAGES  = 2;
  localparam int FIFO_DEPTH   = 4;
  localparam int DROP_W       = 16;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        enable = 1'b1;
  logic [N_CH-1:0]             pulse_in = '0;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [DROP_W-1:0]           drop_count;

  tdc_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) rec_if ();

  tdc_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .MAX_INTERVAL(MAX_INTERVAL),
    .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pulse_in   (pulse_in),
    .rec        (rec_if),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  e;
    logic [CNT_W-1:0] iv;
    logic             c;
  } rec_t;

  rec_t            exp_q[$];
  int              n_tests = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              drops_exp = 0;
  bit              m_armed = 1'b0;
  logic [N_CH-1:0] m_ref = '0;
  int              m_tref = 0;
  bit              rand_ready = 1'b0;

  function automatic void check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endfunction

  // Reference model: each event is a rising edge at bench cycle 'cyc'.
  function automatic void model_push(rec_t r);
    if (exp_q.size() >= FIFO_DEPTH) begin
      if (drops_exp < (1 << DROP_W) - 1) drops_exp++;
    end else begin
      exp_q.push_back(r);
    end
  endfunction

  function automatic void model_event(logic [N_CH-1:0] m);
    rec_t r;
    if (!enable || m == '0) return;
    if ($countones(m) >= 2) begin
      r = '{s: m, e: m, iv: '0, c: 1'b1};
      model_push(r);
    end else if (m_armed && (cyc - m_tref) <= MAX_INTERVAL) begin
      r = '{s: m_ref, e: m, iv: CNT_W'(cyc - m_tref), c: 1'b0};
      model_push(r);
    end
    m_armed = 1'b1;
    m_ref   = m;
    m_tref  = cyc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_ready) rec_if.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic gap(int n);
    repeat (n) tick();
  endtask

  task automatic pulse(logic [N_CH-1:0] m, int width, int spacing);
    pulse_in = m;
    model_event(m);
    gap(width);
    pulse_in = '0;
    gap(spacing - width);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      tick();
      i++;
    end
    gap(8);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer side: every accepted record must match the model's head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rec_if.out_valid && rec_if.out_ready) begin
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_record observed=%0h expected=none",
                 {rec_if.out_start_mask, rec_if.out_end_mask, rec_if.out_interval, rec_if.out_coinc});
        end
        if (exp_q.size() != 0) begin
          check("record", 64'({rec_if.out_start_mask, rec_if.out_end_mask,
                               rec_if.out_interval, rec_if.out_coinc}), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (!rec_if.out_valid) begin
        check("empty_fields", 64'({rec_if.out_start_mask, rec_if.out_end_mask,
                                   rec_if.out_interval, rec_if.out_coinc}), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sp;
    rec_if.out_ready = 1'b0;

    // Reset state
    gap(3);
    check("rst_valid", 64'(rec_if.out_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_drop",  64'(drop_count), 64'd0);
    rst_n = 1'b1;
    gap(5);

    // ch0 then ch1 ten cycles later; measure latency of the record
    pulse(2'b01, 2, 10);
    pulse_in = 2'b10;
    model_event(2'b10);
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 2) pulse_in = '0;
    end while (!rec_if.out_valid && lat < 20);
    pulse_in = '0;
    check("latency", 64'(lat), 64'(SYNC_STAGES + 3));
    check("level_one", 64'(fifo_level), 64'd1);
    check("first_rec", 64'({rec_if.out_start_mask, rec_if.out_end_mask,
                            rec_if.out_interval, rec_if.out_coinc}),
          64'({2'b01, 2'b10, 7'd10, 1'b0}));
    rec_if.out_ready = 1'b1;
    drain();

    // Coincidence from IDLE, then single hit 5 cycles later
    gap(140);
    pulse(2'b11, 2, 5);
    pulse(2'b01, 2, 10);
    drain();

    // Interval boundary: 127 reported, 128 not, then 3
    gap(140);
    pulse(2'b01, 2, 127);
    pulse(2'b01, 2, 128);
    pulse(2'b01, 2, 3);
    pulse(2'b01, 2, 10);
    drain();

    // Overflow: 6 events -> 5 records, depth 4, one dropped
    gap(140);
    rec_if.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse((i % 2 == 0) ? 2'b01 : 2'b10, 2, 8);
    gap(10);
    check("full_level", 64'(fifo_level), 64'(FIFO_DEPTH));
    check("drop_one",   64'(drop_count), 64'(drops_exp));
    check("drop_is_1",  64'(drop_count), 64'd1);
    rec_if.out_ready = 1'b1;
    drain();
    check("drained_valid", 64'(rec_if.out_valid), 64'd0);
    check("drained_level", 64'(fifo_level), 64'd0);

    // Disable while ARMED, pulse ignored; re-enable and measure 4
    gap(140);
    pulse(2'b01, 2, 10);
    enable  = 1'b0;
    m_armed = 1'b0;
    gap(10);
    pulse(2'b10, 2, 10);
    gap(10);
    enable = 1'b1;
    gap(10);
    pulse(2'b01, 2, 4);
    pulse(2'b10, 2, 10);
    drain();
    check("drop_kept", 64'(drop_count), 64'd1);

    // Asynchronous reset with three records queued
    gap(140);
    rec_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse((i % 2 == 0) ? 2'b01 : 2'b10, 2, 8);
    gap(10);
    check("queued_three", 64'(fifo_level), 64'd3);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(rec_if.out_valid), 64'd0);
    check("arst_level", 64'(fifo_level), 64'd0);
    check("arst_drop",  64'(drop_count), 64'd0);
    exp_q.delete();
    m_armed   = 1'b0;
    drops_exp = 0;
    gap(3);
    rst_n = 1'b1;
    rec_if.out_ready = 1'b1;
    gap(5);

    // Randomised traffic with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(124, 132))
                                       : int'($urandom_range(8, 40));
      pulse(N_CH'($urandom_range(1, (1 << N_CH) - 1)), int'($urandom_range(1, 5)), sp);
    end
    rand_ready = 1'b0;
    rec_if.out_ready = 1'b1;
    drain();
    check("rand_drop",  64'(drop_count), 64'(drops_exp));
    check("rand_level", 64'(fifo_level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
